// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Data-memory access controller between the execute stage and a simple
// ready-handshake memory port. Accepts one load/store at a time, rejects
// misaligned halfword/word accesses, drives a word-aligned request with
// byte-lane mask and lane-replicated store data, holds the pipeline while
// the access is in flight and aborts a request that sees no ready within
// TIMEOUT_CYCLES cycles.
//
// Ports
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-high reset
//   mem_op_valid_in, mem_wr_in, mem_size_in,
//   load_unsigned_in, iadder_in, rs2_in          : operation from execute stage
//   ahb_ready_in, dmdata_in                      : memory accept / read data
//   dm_addr_out, dm_wdata_out, dm_wr_mask_out,
//   dm_req_out, dm_wr_req_out                    : memory request
//   stall_out                                    : pipeline hold
//   dmdata_out, load_size_out, load_unsigned_out,
//   iadder_out_1_to_0_out                        : registered data to load unit
//   load_valid_out, store_done_out,
//   misaligned_out, timeout_err_out              : single-cycle status pulses
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_op_valid_in,
    input  logic        mem_wr_in,
    input  logic [1:0]  mem_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_ready_in,
    input  logic [31:0] dmdata_in,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_wdata_out,
    output logic [3:0]  dm_wr_mask_out,
    output logic        dm_req_out,
    output logic        dm_wr_req_out,
    output logic        stall_out,
    output logic [31:0] dmdata_out,
    output logic [1:0]  load_size_out,
    output logic        load_unsigned_out,
    output logic [1:0]  iadder_out_1_to_0_out,
    output logic        load_valid_out,
    output logic        store_done_out,
    output logic        misaligned_out,
    output logic        timeout_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    // Wait count at which a request without ready is abandoned.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  wait_cnt_r;
    logic        mem_wr_r;
    logic        misaligned_s;
    logic        accept_s;

    // Byte-lane write enables; loads never enable a lane.
    function automatic logic [3:0] lane_mask(input logic wr, input logic [1:0] size,
                                             input logic [1:0] lane);
        logic [3:0] mask;
        if (!wr) begin
            mask = 4'b0000;
        end else begin
            case (size)
                2'b00:   mask = 4'b0001 << lane;
                2'b01:   mask = lane[1] ? 4'b1100 : 4'b0011;
                default: mask = 4'b1111;
            endcase
        end
        return mask;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            2'b00:   rep = {4{data[7:0]}};
            2'b01:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    // Alignment check and acceptance decode for a new operation.
    always_comb begin
        misaligned_s = 1'b0;
        if (mem_size_in == 2'b01) begin
            misaligned_s = iadder_in[0];
        end else if (mem_size_in[1]) begin
            misaligned_s = (iadder_in[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
        accept_s = (state_r == IDLE) && mem_op_valid_in && !misaligned_s;
    end

    // State register.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ready is tested before the timeout so it wins on the last count.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (ahb_ready_in) begin
                    state_s = mem_wr_r ? IDLE : RESP;
                end else if (wait_cnt_r == LAST_CNT) begin
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State-decoded outputs; they clear as soon as reset forces IDLE.
    always_comb begin
        dm_req_out     = 1'b0;
        dm_wr_req_out  = 1'b0;
        load_valid_out = 1'b0;
        stall_out      = 1'b0;
        case (state_r)
            IDLE: begin
                stall_out = 1'b0;
            end
            REQ: begin
                dm_req_out    = 1'b1;
                dm_wr_req_out = mem_wr_r;
                stall_out     = 1'b1;
            end
            RESP: begin
                load_valid_out = 1'b1;
                stall_out      = 1'b1;
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

    // Request, sideband, read-data and wait-counter registers.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            dm_addr_out           <= 32'd0;
            dm_wdata_out          <= 32'd0;
            dm_wr_mask_out        <= 4'd0;
            mem_wr_r              <= 1'b0;
            load_size_out         <= 2'd0;
            load_unsigned_out     <= 1'b0;
            iadder_out_1_to_0_out <= 2'd0;
            dmdata_out            <= 32'd0;
            wait_cnt_r            <= 8'd0;
        end else begin
            if (accept_s) begin
                dm_addr_out           <= {iadder_in[31:2], 2'b00};
                dm_wr_mask_out        <= lane_mask(mem_wr_in, mem_size_in, iadder_in[1:0]);
                mem_wr_r              <= mem_wr_in;
                load_size_out         <= mem_size_in;
                load_unsigned_out     <= load_unsigned_in;
                iadder_out_1_to_0_out <= iadder_in[1:0];
                wait_cnt_r            <= 8'd0;
                // A load leaves the previous store data on the bus.
                if (mem_wr_in) begin
                    dm_wdata_out <= lane_data(mem_size_in, rs2_in);
                end
            end else if (state_r == REQ) begin
                if (ahb_ready_in && !mem_wr_r) begin
                    dmdata_out <= dmdata_in;
                end
                if (!ahb_ready_in) begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                end
            end
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            misaligned_out  <= 1'b0;
            store_done_out  <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            misaligned_out  <= (state_r == IDLE) && mem_op_valid_in && misaligned_s;
            store_done_out  <= (state_r == REQ) && ahb_ready_in && mem_wr_r;
            timeout_err_out <= (state_r == REQ) && !ahb_ready_in && (wait_cnt_r == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_op_valid_in, mem_wr_in, load_unsigned_in, ahb_ready_in;
    logic [1:0]  mem_size_in;
    logic [31:0] iadder_in, rs2_in, dmdata_in;
    logic [31:0] dm_addr_out, dm_wdata_out, dmdata_out;
    logic [3:0]  dm_wr_mask_out;
    logic        dm_req_out, dm_wr_req_out, stall_out, load_unsigned_out;
    logic [1:0]  load_size_out, iadder_out_1_to_0_out;
    logic        load_valid_out, store_done_out, misaligned_out, timeout_err_out;

    int total = 0;
    int bad   = 0;

    // Reference model: what the outputs must hold between operations.
    logic [31:0] exp_addr, exp_wdata, exp_dmdata;
    logic [3:0]  exp_mask;
    logic [1:0]  exp_size, exp_lo;
    logic        exp_uns;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .mem_op_valid_in      (mem_op_valid_in),
        .mem_wr_in            (mem_wr_in),
        .mem_size_in          (mem_size_in),
        .load_unsigned_in     (load_unsigned_in),
        .iadder_in            (iadder_in),
        .rs2_in               (rs2_in),
        .ahb_ready_in         (ahb_ready_in),
        .dmdata_in            (dmdata_in),
        .dm_addr_out          (dm_addr_out),
        .dm_wdata_out         (dm_wdata_out),
        .dm_wr_mask_out       (dm_wr_mask_out),
        .dm_req_out           (dm_req_out),
        .dm_wr_req_out        (dm_wr_req_out),
        .stall_out            (stall_out),
        .dmdata_out           (dmdata_out),
        .load_size_out        (load_size_out),
        .load_unsigned_out    (load_unsigned_out),
        .iadder_out_1_to_0_out(iadder_out_1_to_0_out),
        .load_valid_out       (load_valid_out),
        .store_done_out       (store_done_out),
        .misaligned_out       (misaligned_out),
        .timeout_err_out      (timeout_err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_dmdata = 32'd0;
        exp_mask = 4'd0;  exp_size = 2'd0;  exp_lo = 2'd0; exp_uns = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return {dm_addr_out[15:0], dm_wdata_out[15:0], dmdata_out[15:0], dm_wr_mask_out,
                dm_req_out, dm_wr_req_out, stall_out, load_size_out, load_unsigned_out,
                iadder_out_1_to_0_out, load_valid_out, store_done_out, misaligned_out,
                timeout_err_out} | {63'd0, |{dm_addr_out[31:16], dm_wdata_out[31:16], dmdata_out[31:16]}};
    endfunction

    // Drive one operation and follow it to completion against the model.
    // rdy_delay = number of REQ cycles without ready; >= T means never ready.
    task automatic run_op(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int rdy_delay,
                          input logic [31:0] rdata, input string tag, output int req_cycles);
        int  a;
        bit  mis, done;
        a   = int'(addr % 32'd4);
        mis = (size == 2'd1 && (a % 2) != 0) || (size >= 2'd2 && a != 0);
        req_cycles = 0;
        mem_op_valid_in = 1'b1; mem_wr_in = wr; mem_size_in = size; load_unsigned_in = uns;
        iadder_in = addr; rs2_in = wd; ahb_ready_in = 1'b0; dmdata_in = $urandom;
        tick();
        if (mis) begin
            mem_op_valid_in = 1'b0;
            total++;
            if ({misaligned_out, stall_out, dm_req_out} !== 3'b100) begin
                bad++; $display("FAIL %s misalign: got mis/stall/req=%b want 100", tag,
                                {misaligned_out, stall_out, dm_req_out});
            end
            tick();
            total++;
            if ({misaligned_out, stall_out, dm_req_out} !== 3'b000
                || {load_size_out, load_unsigned_out, iadder_out_1_to_0_out} !== {exp_size, exp_uns, exp_lo}) begin
                bad++; $display("FAIL %s misalign_after: got mis/stall/req=%b sideband=%b", tag,
                                {misaligned_out, stall_out, dm_req_out},
                                {load_size_out, load_unsigned_out, iadder_out_1_to_0_out});
            end
            return;
        end
        exp_addr = addr - (addr % 32'd4);
        if (!wr)            exp_mask = 4'd0;
        else if (size == 0) exp_mask = 4'(1 << a);
        else if (size == 1) exp_mask = 4'(3 << (a - a % 2));
        else                exp_mask = 4'd15;
        if (wr) begin
            if (size == 0)      exp_wdata = (wd & 32'hFF) * 32'h01010101;
            else if (size == 1) exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
            else                exp_wdata = wd;
        end
        exp_size = size; exp_uns = uns; exp_lo = 2'(a);
        req_cycles = 1;
        total++;
        if ({stall_out, dm_req_out, dm_wr_req_out} !== {2'b11, wr} || dm_addr_out !== exp_addr
            || dm_wr_mask_out !== exp_mask || dm_wdata_out !== exp_wdata
            || {load_size_out, load_unsigned_out, iadder_out_1_to_0_out} !== {exp_size, exp_uns, exp_lo}) begin
            bad++; $display("FAIL %s accept: got addr=%h mask=%b wdata=%h ctl=%b want addr=%h mask=%b wdata=%h ctl=%b",
                            tag, dm_addr_out, dm_wr_mask_out, dm_wdata_out, {stall_out, dm_req_out, dm_wr_req_out},
                            exp_addr, exp_mask, exp_wdata, {2'b11, wr});
        end
        done = 0;
        for (int k = 0; k < T && !done; k++) begin
            // Upstream noise while stalled must be ignored.
            mem_op_valid_in = 1'b1; iadder_in = $urandom; rs2_in = $urandom;
            mem_wr_in = 1'($urandom); mem_size_in = 2'($urandom);
            ahb_ready_in = (k == rdy_delay);
            dmdata_in = (k == rdy_delay) ? rdata : $urandom;
            tick();
            ahb_ready_in = 1'b0;
            if (k == rdy_delay) begin
                done = 1;
                if (wr) begin
                    mem_op_valid_in = 1'b0;
                    total++;
                    if ({store_done_out, stall_out, dm_req_out, load_valid_out, timeout_err_out} !== 5'b10000) begin
                        bad++; $display("FAIL %s store_done: got done/stall/req/lv/to=%b want 10000", tag,
                                        {store_done_out, stall_out, dm_req_out, load_valid_out, timeout_err_out});
                    end
                end else begin
                    exp_dmdata = rdata;
                    total++;
                    if ({load_valid_out, stall_out, dm_req_out, store_done_out, timeout_err_out} !== 5'b11000
                        || dmdata_out !== exp_dmdata) begin
                        bad++; $display("FAIL %s load_valid: got lv/stall/req/sd/to=%b data=%h want 11000 data=%h", tag,
                                        {load_valid_out, stall_out, dm_req_out, store_done_out, timeout_err_out},
                                        dmdata_out, exp_dmdata);
                    end
                    tick();
                    mem_op_valid_in = 1'b0;
                    total++;
                    if ({load_valid_out, stall_out, dm_req_out} !== 3'b000 || dmdata_out !== exp_dmdata) begin
                        bad++; $display("FAIL %s resp_end: got lv/stall/req=%b data=%h want 000 data=%h", tag,
                                        {load_valid_out, stall_out, dm_req_out}, dmdata_out, exp_dmdata);
                    end
                end
            end else if (k == T - 1) begin
                done = 1;
                mem_op_valid_in = 1'b0;
                total++;
                if ({timeout_err_out, stall_out, dm_req_out, store_done_out, load_valid_out} !== 5'b10000) begin
                    bad++; $display("FAIL %s timeout: got to/stall/req/sd/lv=%b want 10000", tag,
                                    {timeout_err_out, stall_out, dm_req_out, store_done_out, load_valid_out});
                end
            end else begin
                req_cycles++;
                total++;
                if ({dm_req_out, stall_out, dm_wr_req_out} !== {2'b11, wr} || dm_addr_out !== exp_addr
                    || dm_wr_mask_out !== exp_mask || dm_wdata_out !== exp_wdata
                    || {store_done_out, load_valid_out, timeout_err_out, misaligned_out} !== 4'b0000) begin
                    bad++; $display("FAIL %s req_hold: got addr=%h mask=%b wdata=%h req/stall/wr=%b want addr=%h mask=%b wdata=%h",
                                    tag, dm_addr_out, dm_wr_mask_out, dm_wdata_out,
                                    {dm_req_out, stall_out, dm_wr_req_out}, exp_addr, exp_mask, exp_wdata);
                end
            end
        end
        tick();
        total++;
        if ({store_done_out, load_valid_out, timeout_err_out, misaligned_out, stall_out, dm_req_out} !== 6'd0
            || dmdata_out !== exp_dmdata
            || {load_size_out, load_unsigned_out, iadder_out_1_to_0_out} !== {exp_size, exp_uns, exp_lo}) begin
            bad++; $display("FAIL %s idle_after: got pulses=%b data=%h sideband=%b want 0 data=%h sideband=%b", tag,
                            {store_done_out, load_valid_out, timeout_err_out, misaligned_out, stall_out, dm_req_out},
                            dmdata_out, {load_size_out, load_unsigned_out, iadder_out_1_to_0_out},
                            exp_dmdata, {exp_size, exp_uns, exp_lo});
        end
    endtask

    task automatic test_reset();
        total++;
        if (all_outputs() !== 64'd0) begin
            bad++; $display("FAIL reset_hold: got %h want 0", all_outputs());
        end
        rst = 1'b0;
        tick();
        total++;
        if (all_outputs() !== 64'd0) begin
            bad++; $display("FAIL reset_release: got %h want 0", all_outputs());
        end
    endtask

    task automatic test_lbu();
        int rc;
        run_op(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 0, 32'hAB00_0000, "lbu", rc);
        total++;
        if (dm_addr_out !== 32'h0000_1000 || dm_wr_mask_out !== 4'b0000 || dmdata_out !== 32'hAB00_0000
            || iadder_out_1_to_0_out !== 2'b11 || load_unsigned_out !== 1'b1) begin
            bad++; $display("FAIL lbu_const: got addr=%h mask=%b data=%h lo=%b uns=%b want 00001000 0000 ab000000 11 1",
                            dm_addr_out, dm_wr_mask_out, dmdata_out, iadder_out_1_to_0_out, load_unsigned_out);
        end
    endtask

    task automatic test_sh();
        int rc;
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 32'd0, "sh", rc);
        total++;
        if (dm_wr_mask_out !== 4'b1100 || dm_wdata_out !== 32'hBEEF_BEEF || dm_addr_out !== 32'h0000_2000) begin
            bad++; $display("FAIL sh_const: got mask=%b wdata=%h addr=%h want 1100 beefbeef 00002000",
                            dm_wr_mask_out, dm_wdata_out, dm_addr_out);
        end
    endtask

    task automatic test_misaligned();
        int rc;
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 0, 32'd0, "lw_mis", rc);
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_3003, 32'd0, 0, 32'd0, "sh_mis", rc);
    endtask

    task automatic test_timeout();
        int rc;
        run_op(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h1234_5678, 99, 32'd0, "sw_to", rc);
        total++;
        if (rc !== T) begin
            bad++; $display("FAIL timeout_req_cycles: got %0d want %0d", rc, T);
        end
    endtask

    task automatic test_ready_on_last();
        int rc;
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'd0, T - 1, 32'hCAFE_F00D, "lw_last", rc);
        total++;
        if (rc !== T || dmdata_out !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL ready_last: got cycles=%0d data=%h want %0d cafef00d", rc, dmdata_out, T);
        end
    endtask

    task automatic test_reset_mid();
        int rc;
        mem_op_valid_in = 1'b1; mem_wr_in = 1'b0; mem_size_in = 2'b10; iadder_in = 32'h0000_6008;
        ahb_ready_in = 1'b0;
        tick();
        mem_op_valid_in = 1'b0;
        tick();
        tick();
        total++;
        if (dm_req_out !== 1'b1) begin
            bad++; $display("FAIL mid_req: got req=%b want 1", dm_req_out);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (all_outputs() !== 64'd0) begin
            bad++; $display("FAIL reset_async: got %h want 0", all_outputs());
        end
        model_reset();
        tick();
        rst = 1'b0;
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'd0, 1, 32'h0BAD_BEEF, "lw_after_rst", rc);
    endtask

    task automatic test_random();
        int rc;
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, T + 1)), $urandom, "rand", rc);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_op_valid_in = 1'b0; mem_wr_in = 1'b0; mem_size_in = 2'b00; load_unsigned_in = 1'b0;
        iadder_in = 32'd0; rs2_in = 32'd0; ahb_ready_in = 1'b0; dmdata_in = 32'd0;
        model_reset();
        tick();
        tick();
        test_reset();
        test_lbu();
        test_sh();
        test_misaligned();
        test_timeout();
        test_ready_on_last();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
